// File: rtl/jt5205_adpcm_mc.sv
// jt5205_adpcm_mc: time-multiplexed multi-channel MSM5205-style ADPCM decoder.
// A single shift-add engine decodes one nibble at a time. Every channel keeps
// its own step index and accumulator in internal arrays.
// Optional feature macro: JT5205_MC_MIX_EN adds a registered, saturated sum of
// all accumulators on 'mix'; without it 'mix' is tied to zero.
module jt5205_adpcm_mc #(
    parameter int CH  = 4,
    parameter int CHW = 2,
    parameter int DW  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    input  logic                 din_valid,
    input  logic [CHW-1:0]       din_ch,
    input  logic [3:0]           din,
    output logic                 din_ready,
    input  logic [CH-1:0]        b3,
    input  logic [CH-1:0]        ch_clr,
    output logic signed [DW-1:0] snd,
    output logic [CHW-1:0]       snd_ch,
    output logic                 snd_valid,
    output logic signed [DW-1:0] mix
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MUL0,
        S_MUL1,
        S_MUL2,
        S_WRITE
    } state_t;

    localparam logic [10:0] DELTA [49] = '{
        11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
        11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
        11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
        11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
        11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
        11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
        11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
    };

    localparam logic signed [DW+1:0] SUM_MAX = (DW+2)'((2**(DW-1)) - 1);
    localparam logic signed [DW+1:0] SUM_MIN = (DW+2)'(-(2**(DW-1)));

    state_t                state_q, state_d;
    logic [CHW-1:0]        ch_q, ch_d;
    logic [3:0]            code_q, code_d;
    logic [DW-1:0]         step_q, step_d;
    logic [DW:0]           q_q, q_d;
    logic [5:0]            idx_q [CH];
    logic [5:0]            idx_d [CH];
    logic signed [DW-1:0]  acc_q [CH];
    logic signed [DW-1:0]  acc_d [CH];
    logic signed [DW-1:0]  snd_q, snd_d;
    logic [CHW-1:0]        snd_ch_q, snd_ch_d;
    logic                  snd_valid_q, snd_valid_d;

    logic                  din_in_range;
    logic                  ch_in_range;
    logic                  mode3;
    logic [CHW-1:0]        sel_ch;
    logic [5:0]            idx_cur;
    logic [6:0]            idx_up;
    logic [5:0]            idx_next;
    logic [DW-1:0]         step_lookup;
    logic signed [DW+1:0]  acc_ext;
    logic signed [DW+1:0]  q_ext;
    logic signed [DW+1:0]  acc_sum;
    logic signed [DW-1:0]  acc_sat;

    assign din_ready = (state_q == S_IDLE) & ~|ch_clr;
    assign snd       = snd_q;
    assign snd_ch    = snd_ch_q;
    assign snd_valid = snd_valid_q;

    // Shared datapath: channel selection, step lookup, saturating add and index adaptation.
    always_comb begin
        din_in_range = ({1'b0, din_ch} < (CHW+1)'(CH));
        mode3        = din_in_range ? b3[din_ch] : 1'b0;
        ch_in_range  = ({1'b0, ch_q} < (CHW+1)'(CH));
        sel_ch       = ch_in_range ? ch_q : '0;
        idx_cur      = idx_q[sel_ch];
        step_lookup  = {{(DW-11){1'b0}}, DELTA[idx_cur]} << (DW-12);
        acc_ext      = {{2{acc_q[sel_ch][DW-1]}}, acc_q[sel_ch]};
        q_ext        = {1'b0, q_q};
        acc_sum      = code_q[3] ? (acc_ext - q_ext) : (acc_ext + q_ext);
        if (acc_sum > SUM_MAX) begin
            acc_sat = SUM_MAX[DW-1:0];
        end else if (acc_sum < SUM_MIN) begin
            acc_sat = SUM_MIN[DW-1:0];
        end else begin
            acc_sat = acc_sum[DW-1:0];
        end
        idx_up = {1'b0, idx_cur} + {4'b0, code_q[1:0], 1'b0} + 7'd2;
        if (code_q[2]) begin
            idx_next = (idx_up > 7'd48) ? 6'd48 : idx_up[5:0];
        end else begin
            idx_next = (idx_cur == 6'd0) ? 6'd0 : (idx_cur - 6'd1);
        end
    end

    // Next-state logic: clear/accept in IDLE, then load, three shift-add steps and write-back.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        code_d      = code_q;
        step_d      = step_q;
        q_d         = q_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        snd_d       = snd_q;
        snd_ch_d    = snd_ch_q;
        snd_valid_d = 1'b0;
        if (cen) begin
            case (state_q)
                S_IDLE: begin
                    if (|ch_clr) begin
                        for (int i = 0; i < CH; i++) begin
                            if (ch_clr[i]) begin
                                idx_d[i] = '0;
                                acc_d[i] = '0;
                            end
                        end
                    end else if (din_valid) begin
                        ch_d    = din_ch;
                        code_d  = mode3 ? {din[2], din[1:0], 1'b0} : din;
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    step_d  = step_lookup;
                    q_d     = {1'b0, step_lookup >> 3};
                    state_d = S_MUL0;
                end
                S_MUL0: begin
                    if (code_q[2]) q_d = q_q + {1'b0, step_q};
                    state_d = S_MUL1;
                end
                S_MUL1: begin
                    if (code_q[1]) q_d = q_q + {1'b0, step_q >> 1};
                    state_d = S_MUL2;
                end
                S_MUL2: begin
                    if (code_q[0]) q_d = q_q + {1'b0, step_q >> 2};
                    state_d = S_WRITE;
                end
                S_WRITE: begin
                    if (ch_in_range) begin
                        acc_d[sel_ch] = acc_sat;
                        idx_d[sel_ch] = idx_next;
                        snd_d         = acc_sat;
                        snd_ch_d      = ch_q;
                        snd_valid_d   = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, per-channel arrays and output registers; synchronous reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            code_q      <= '0;
            step_q      <= '0;
            q_q         <= '0;
            snd_q       <= '0;
            snd_ch_q    <= '0;
            snd_valid_q <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                idx_q[i] <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            code_q      <= code_d;
            step_q      <= step_d;
            q_q         <= q_d;
            snd_q       <= snd_d;
            snd_ch_q    <= snd_ch_d;
            snd_valid_q <= snd_valid_d;
            for (int i = 0; i < CH; i++) begin
                idx_q[i] <= idx_d[i];
                acc_q[i] <= acc_d[i];
            end
        end
    end

`ifdef JT5205_MC_MIX_EN
    localparam logic signed [DW+CHW-1:0] MIX_MAX = (DW+CHW)'((2**(DW-1)) - 1);
    localparam logic signed [DW+CHW-1:0] MIX_MIN = (DW+CHW)'(-(2**(DW-1)));

    logic signed [DW+CHW-1:0] mix_sum;
    logic signed [DW-1:0]     mix_q, mix_d;

    // Wide sum of all accumulators, saturated once, refreshed only on cen.
    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < CH; i++) begin
            mix_sum = mix_sum + {{CHW{acc_q[i][DW-1]}}, acc_q[i]};
        end
        mix_d = mix_q;
        if (cen) begin
            if (mix_sum > MIX_MAX) begin
                mix_d = MIX_MAX[DW-1:0];
            end else if (mix_sum < MIX_MIN) begin
                mix_d = MIX_MIN[DW-1:0];
            end else begin
                mix_d = mix_sum[DW-1:0];
            end
        end
    end

    // Mix output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mix_q <= '0;
        end else begin
            mix_q <= mix_d;
        end
    end

    assign mix = mix_q;
`else
    assign mix = '0;
`endif

endmodule

// File: doc/jt5205_adpcm_mc.md
Name: jt5205_adpcm_mc

Overview:
- Time-multiplexed, multi-channel OKI/MSM5205-style ADPCM decoder.
- One shared shift-add engine serves CH channels. Per-channel step index and accumulator live in internal state arrays.
- Sits between the sample-fetch logic, which pushes nibbles through a valid/ready handshake, and the mixer. It emits one decoded sample per accepted nibble, tagged with its channel.

Parameters:
CH, 4, number of channels (1..16)
CHW, 2, channel-id width, equal to max(1, clog2(CH))
DW, 12, output/accumulator width (12..16); step values are scaled left by DW-12

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
cen  in  1  clock enable; FSM, arrays and outputs advance only on clk edges with cen=1
din_valid  in  1  nibble request
din_ch  in  CHW  target channel
din  in  4  ADPCM code: [3] sign, [2:0] magnitude
din_ready  out  1  engine can accept this cycle
b3  in  CH  per-channel 3-bit mode
ch_clr  in  CH  per-channel clear request (level)
snd  out  DW  signed decoded sample
snd_ch  out  CHW  channel of snd
snd_valid  out  1  one-clk pulse: snd/snd_ch updated
mix  out  DW  signed saturated sum of all accumulators (see optional feature)

Behaviour:
- Reset (any cycle, cen ignored): FSM to IDLE; all idx[]=0, acc[]=0; snd=0, snd_ch=0, snd_valid=0, mix=0. An operation in flight is aborted with no snd_valid.
- din_ready = (state==IDLE) & ~|ch_clr. It is combinational.
- IDLE, cen=1:
  - If |ch_clr: every flagged channel gets idx=0, acc=0; stay IDLE. Clear has priority over din_valid.
  - Else if din_valid: latch ch, code, b3[ch]; go to LOAD.
- Channel out of range (din_ch >= CH): accepted, then dropped; return to IDLE with no state change and no snd_valid.
- Effective code:
  - 4-bit mode: code = din.
  - 3-bit mode: code = {din[2], din[1:0], 1'b0}.
- LOAD: step = delta[idx[ch]] << (DW-12), using the standard 49-entry table 16,17,19,...,1411,1552. Set q = step>>3.
- MUL0/MUL1/MUL2 (one cen each): q += code[2-k] ? (step>>k) : 0, for k=0,1,2.
  - Result: q = step/8 + code[2]·step + code[1]·step/2 + code[0]·step/4, each term truncated.
- WRITE:
  - acc[ch] = sat(acc[ch] ± q): minus when code[3]=1. Saturation limits are +2^(DW-1)-1 and -2^(DW-1).
  - idx[ch] update: if code[2]=1, idx + {2,4,6,8}[code[1:0]], clamped to 48. Else idx-1, clamped to 0.
  - snd = new acc, snd_ch = ch, snd_valid=1 for exactly that clk. Return to IDLE.
- Latency: accept edge to WRITE edge is 5 cen edges. Throughput is one nibble per 6 cen edges.
- ch_clr asserted while busy is not sampled until IDLE. Requesters hold it as a level.
- snd and snd_ch hold their values between pulses.
- Channels not addressed keep idx and acc untouched.

Optional Feature:
JT5205_MC_MIX_EN
- Defined:
  - mix is registered on every cen edge as the saturated (DW) sum of acc[0..CH-1].
  - The summation uses DW+CHW internal width and saturates once.
  - Clear and reset zero it on the following cen edge.
- Undefined: mix is constant 0 and the adder tree is not synthesised.

Test Plan:
- Reset, ch0 din=4'h0 -> snd=2 (16>>3), snd_ch=0, idx[0] stays 0; snd_valid exactly 1 clk, 5 cen after acceptance.
- Reset, ch1 din=4'h7 -> snd=30 (2+16+8+4), idx[1]=8. Then ch1 din=4'hF, where step=34 -> q=4+34+17+8=63, snd=30-63=-33.
- ch2 fed 4'h7 repeatedly -> idx walks 8,16,...,48 and stays at 48. snd saturates at 2047 (DW=12) and never wraps. Then 4'h8 repeated -> idx decreases by 1 per nibble.
- b3[3]=1, din=3'b011 on ch3 -> code 4'h6, q=2+16+8=26, snd=26, idx=6.
- Busy window: din_valid held asserted with varying ch -> din_ready low for 5 cen edges, and only the nibble present at each ready cycle is decoded. ch_clr=4'b0010 with din_valid in IDLE -> clear wins, din_ready=0, next ch1 output starts from 0.
- rst pulsed during MUL1 -> no snd_valid. snd=0 and all channels decode from idx 0 afterwards. With JT5205_MC_MIX_EN: ch0=30, ch1=-33 -> mix=-3.
